// File: rtl/pht_gshare_if.sv
// Prediction/update bus between the branch-prediction pipeline and the
// gshare pattern-history table. The pipeline (master) drives lookups,
// stalls and EX-stage resolutions; the table (slave) returns the prediction,
// the hashed index and the GHR checkpoint.
interface pht_gshare_if #(
    parameter int ADDR_W = 8,
    parameter int GHR_W  = 8
);
    logic              stallreq;
    logic              pred_valid;
    logic [ADDR_W-1:0] pred_pc_idx;
    logic              pred_direct;
    logic [ADDR_W-1:0] pred_index;
    logic [GHR_W-1:0]  ghr_out;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_index;
    logic              upd_taken;
    logic              upd_mispredict;
    logic [GHR_W-1:0]  upd_ghr;

    modport master (
        output stallreq, pred_valid, pred_pc_idx,
        output upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr,
        input  pred_direct, pred_index, ghr_out
    );

    modport slave (
        input  stallreq, pred_valid, pred_pc_idx,
        input  upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr,
        output pred_direct, pred_index, ghr_out
    );
endinterface

// File: rtl/pht_gshare.sv
// Gshare pattern-history table: 2^ADDR_W saturating counters with per-entry
// valid bits, indexed by PC index XOR speculative global history.
// EX-stage updates pass through a one-entry write buffer that always drains
// on the next unstalled cycle; consecutive updates to one index chain
// through the buffer so each update is exactly one counter step.
// Optional feature macro: PHT_BYPASS_EN -- the read path also looks at the
// write buffer so an update is visible one cycle earlier.
module pht_gshare #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 2,
    parameter int GHR_W  = 8
) (
    input  logic           clk,
    input  logic           resetn,
    pht_gshare_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};

    // Table storage: counters carry no reset, only the valid bits do.
    logic [CNT_W-1:0]  cnt_mem [DEPTH];
    logic [DEPTH-1:0]  valid_reg;

    logic [GHR_W-1:0]  ghr_reg;
    logic [GHR_W-1:0]  ghr_next;

    logic              wb_valid_reg;
    logic [ADDR_W-1:0] wb_idx_reg;
    logic [CNT_W-1:0]  wb_cnt_reg;
    logic              wb_valid_next;
    logic [ADDR_W-1:0] wb_idx_next;
    logic [CNT_W-1:0]  wb_cnt_next;

    logic              advance;
    logic              commit;
    logic [DEPTH-1:0]  commit_onehot;
    logic [ADDR_W-1:0] ghr_ext;
    logic [ADDR_W-1:0] pred_index_w;
    logic              table_taken;
    logic              pred_dir_w;
    logic [GHR_W-1:0]  ghr_shifted;
    logic [GHR_W-1:0]  ghr_repaired;
    logic              base_from_wb;
    logic [CNT_W-1:0]  base_cnt;
    logic              base_valid;
    logic [CNT_W-1:0]  upd_cnt;

    // State only moves when out of reset and the pipeline is not stalled.
    assign advance = resetn & ~bus.stallreq;
    assign commit  = advance & wb_valid_reg;

    // Per-entry decode of the buffered index, used to set valid bits on commit.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_commit_dec
            assign commit_onehot[gi] = commit && (wb_idx_reg == ADDR_W'(gi));
        end
    endgenerate

    // Zero-extend the history into the index width; forced to zero in reset
    // so the hashed index equals the PC index while resetn is low.
    always_comb begin
        ghr_ext = '0;
        if (resetn) begin
            ghr_ext[GHR_W-1:0] = ghr_reg;
        end
    end

    assign pred_index_w = bus.pred_pc_idx ^ ghr_ext;
    assign table_taken  = valid_reg[pred_index_w] & cnt_mem[pred_index_w][CNT_W-1];

    // Prediction read path, optionally forwarding the pending buffered write.
    always_comb begin
        pred_dir_w = table_taken;
`ifdef PHT_BYPASS_EN
        if (wb_valid_reg && (wb_idx_reg == pred_index_w)) begin
            pred_dir_w = wb_cnt_reg[CNT_W-1];
        end
`endif
    end

    assign bus.pred_direct = resetn & pred_dir_w;
    assign bus.pred_index  = pred_index_w;
    assign bus.ghr_out     = resetn ? ghr_reg : '0;

    // History shift operands; a one-bit history is just the latest outcome.
    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign ghr_shifted  = bus.pred_direct;
            assign ghr_repaired = bus.upd_taken;
        end else begin : g_ghr_wide
            assign ghr_shifted  = {ghr_reg[GHR_W-2:0], bus.pred_direct};
            assign ghr_repaired = {bus.upd_ghr[GHR_W-2:0], bus.upd_taken};
        end
    endgenerate

    // Next history: mispredict repair wins over the speculative shift.
    always_comb begin
        ghr_next = ghr_reg;
        if (bus.upd_valid && bus.upd_mispredict) begin
            ghr_next = ghr_repaired;
        end else if (bus.pred_valid) begin
            ghr_next = ghr_shifted;
        end
    end

    // Update arithmetic: base comes from the buffer when it holds the same
    // index (its value has not reached the table yet), else from the table.
    always_comb begin
        base_from_wb = wb_valid_reg && (wb_idx_reg == bus.upd_index);
        base_cnt     = base_from_wb ? wb_cnt_reg : cnt_mem[bus.upd_index];
        base_valid   = base_from_wb | valid_reg[bus.upd_index];
        upd_cnt      = base_cnt;
        if (!base_valid) begin
            upd_cnt = bus.upd_taken ? WEAK_T : WEAK_NT;
        end else if (bus.upd_taken) begin
            upd_cnt = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + 1'b1;
        end else begin
            upd_cnt = (base_cnt == CNT_MIN) ? CNT_MIN : base_cnt - 1'b1;
        end
    end

    // Next buffer contents: every unstalled cycle drains the old entry and
    // loads whatever update is presented (or empties the buffer).
    always_comb begin
        wb_valid_next = wb_valid_reg;
        wb_idx_next   = wb_idx_reg;
        wb_cnt_next   = wb_cnt_reg;
        if (!bus.stallreq) begin
            wb_valid_next = bus.upd_valid;
            wb_idx_next   = bus.upd_index;
            wb_cnt_next   = upd_cnt;
        end
    end

    // Control state: history, buffer and valid bits, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ghr_reg      <= '0;
            wb_valid_reg <= 1'b0;
            valid_reg    <= '0;
        end else begin
            if (!bus.stallreq) begin
                ghr_reg <= ghr_next;
            end
            wb_valid_reg <= wb_valid_next;
            valid_reg    <= valid_reg | commit_onehot;
        end
    end

    // Buffer payload needs no reset; it is qualified by wb_valid_reg.
    always_ff @(posedge clk) begin
        wb_idx_reg <= wb_idx_next;
        wb_cnt_reg <= wb_cnt_next;
    end

    // Counter array write port: drain the buffer into the table.
    always_ff @(posedge clk) begin
        if (commit) begin
            cnt_mem[wb_idx_reg] <= wb_cnt_reg;
        end
    end
endmodule

// File: tb/tb_pht_gshare.sv
// Self-checking bench for pht_gshare (default parameters: 256 entries,
// 2-bit counters, 8-bit history). A behavioural model tracks the logical
// counter value of every entry, the one most recent update that the table
// may not show yet, and the global history.
module tb_pht_gshare;
    logic clk;
    logic resetn;

    int checks = 0;
    int errors = 0;

    pht_gshare_if #(.ADDR_W(8), .GHR_W(8)) bus ();

    pht_gshare #(.ADDR_W(8), .CNT_W(2), .GHR_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int         m_cnt [256];
    bit         m_val [256];
    logic [7:0] m_ghr;
    bit         pend;
    int         pend_idx;
    int         pend_cnt;
    bit         pend_val;

    // Expected direction for a hashed index as seen by a read this cycle.
    function automatic bit exp_dir(input logic [7:0] idx);
        int c;
        bit v;
        if (resetn !== 1'b1) return 1'b0;
        c = m_cnt[idx];
        v = m_val[idx];
`ifndef PHT_BYPASS_EN
        if (pend && pend_idx == int'(idx)) begin
            c = pend_cnt;
            v = pend_val;
        end
`endif
        return v && (c >= 2);
    endfunction

    function automatic logic [7:0] exp_ghr();
        return (resetn === 1'b1) ? m_ghr : 8'h00;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit pd;
        int idx, oldc, newc;
        if (resetn !== 1'b1) begin
            foreach (m_val[i]) m_val[i] = 1'b0;
            m_ghr = 8'h00;
            pend  = 1'b0;
            return;
        end
        if (bus.stallreq) return;
        pd   = bus.pred_valid ? exp_dir(bus.pred_pc_idx ^ m_ghr) : 1'b0;
        pend = 1'b0;
        if (bus.upd_valid) begin
            idx  = int'(bus.upd_index);
            oldc = m_cnt[idx];
            if (!m_val[idx])        newc = bus.upd_taken ? 2 : 1;
            else if (bus.upd_taken) newc = (oldc + 1 > 3) ? 3 : oldc + 1;
            else                    newc = (oldc - 1 < 0) ? 0 : oldc - 1;
            pend     = 1'b1;
            pend_idx = idx;
            pend_cnt = oldc;
            pend_val = m_val[idx];
            m_cnt[idx] = newc;
            m_val[idx] = 1'b1;
            $display("[%0t] upd idx=%02h taken=%0b mis=%0b cnt %0d->%0d",
                     $time, idx, bus.upd_taken, bus.upd_mispredict,
                     pend_val ? oldc : -1, newc);
        end
        if (bus.upd_valid && bus.upd_mispredict)
            m_ghr = {bus.upd_ghr[6:0], bus.upd_taken};
        else if (bus.pred_valid)
            m_ghr = {m_ghr[6:0], pd};
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallreq       = 1'b0;
        bus.pred_valid     = 1'b0;
        bus.upd_valid      = 1'b0;
        bus.upd_taken      = 1'b0;
        bus.upd_mispredict = 1'b0;
        bus.upd_index      = 8'h00;
        bus.upd_ghr        = 8'h00;
    endtask

    task automatic set_upd(input logic [7:0] idx, input bit taken);
        bus.upd_valid      = 1'b1;
        bus.upd_index      = idx;
        bus.upd_taken      = taken;
        bus.upd_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.pred_pc_idx = 8'hA5;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.pred_direct !== 1'b0 || bus.ghr_out !== 8'h00 || bus.pred_index !== 8'hA5) begin
            errors++;
            $display("FAIL reset_outputs: dir=%b ghr=%h idx=%h, required 0/00/a5",
                     bus.pred_direct, bus.ghr_out, bus.pred_index);
        end
        cycle();
        cycle();
        resetn = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.pred_pc_idx = 8'(i);
            #1;
            checks++;
            if (bus.pred_direct !== 1'b0 || bus.pred_index !== 8'(i)) begin
                errors++;
                $display("FAIL reset_sweep[%02h]: dir=%b idx=%h, required 0/%02h",
                         i, bus.pred_direct, bus.pred_index, i);
            end
            cycle();
        end
        checks++;
        if (bus.ghr_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_ghr: ghr=%h, required 00", bus.ghr_out);
        end
    endtask

    task automatic test_first_update();
        set_upd(8'h12, 1'b1);
        cycle();
        idle_inputs();
        bus.pred_pc_idx = 8'h12;
        #1;
        checks++;
        if (bus.pred_direct !== exp_dir(8'h12)) begin
            errors++;
            $display("FAIL first_update_n1: dir=%b, required %b", bus.pred_direct, exp_dir(8'h12));
        end
        cycle();
        checks++;
        if (bus.pred_direct !== 1'b1) begin
            errors++;
            $display("FAIL first_update_n2: dir=%b, required 1", bus.pred_direct);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            set_upd(8'h12, 1'b1);
            cycle();
        end
        idle_inputs();
        cycle();
        bus.pred_pc_idx = 8'h12;
        #1;
        checks++;
        if (bus.pred_direct !== 1'b1) begin
            errors++;
            $display("FAIL saturate_up: dir=%b, required 1", bus.pred_direct);
        end
        for (int i = 0; i < 2; i++) begin
            set_upd(8'h12, 1'b0);
            cycle();
        end
        idle_inputs();
        cycle();
        checks++;
        if (bus.pred_direct !== 1'b0 || m_cnt[8'h12] != 1) begin
            errors++;
            $display("FAIL saturate_down: dir=%b model_cnt=%0d, required 0 / 1",
                     bus.pred_direct, m_cnt[8'h12]);
        end
    endtask

    task automatic test_back_to_back();
        set_upd(8'h34, 1'b1);
        cycle();
        set_upd(8'h34, 1'b1);
        cycle();
        set_upd(8'h34, 1'b0);
        cycle();
        idle_inputs();
        cycle();
        bus.pred_pc_idx = 8'h34;
        #1;
        checks++;
        if (bus.pred_direct !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: dir=%b, required 1 (chain 10->11->10)", bus.pred_direct);
        end
    endtask

    task automatic test_ghr();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        set_upd(8'h60, 1'b1);
        cycle();
        idle_inputs();
        cycle();
        for (int i = 0; i < 3; i++) begin
            bus.pred_valid  = 1'b1;
            bus.pred_pc_idx = 8'h60 ^ m_ghr;
            #1;
            checks++;
            if (bus.pred_direct !== 1'b1) begin
                errors++;
                $display("FAIL ghr_pred[%0d]: dir=%b, required 1", i, bus.pred_direct);
            end
            cycle();
        end
        checks++;
        if (bus.ghr_out !== 8'h07) begin
            errors++;
            $display("FAIL ghr_shift: ghr=%h, required 07", bus.ghr_out);
        end
        bus.pred_valid     = 1'b1;
        bus.pred_pc_idx    = 8'h60 ^ m_ghr;
        set_upd(8'h61, 1'b0);
        bus.upd_mispredict = 1'b1;
        bus.upd_ghr        = 8'h05;
        cycle();
        idle_inputs();
        checks++;
        if (bus.ghr_out !== 8'h0A) begin
            errors++;
            $display("FAIL ghr_repair: ghr=%h, required 0a", bus.ghr_out);
        end
    endtask

    task automatic test_stall();
        logic [7:0] g0;
        g0 = bus.ghr_out;
        checks++;
        if (g0 !== exp_ghr()) begin
            errors++;
            $display("FAIL stall_pre_ghr: ghr=%h, required %h", g0, exp_ghr());
        end
        bus.stallreq    = 1'b1;
        bus.pred_valid  = 1'b1;
        bus.pred_pc_idx = 8'h70 ^ exp_ghr();
        set_upd(8'h70, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (bus.ghr_out !== exp_ghr() || bus.pred_direct !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ghr=%h dir=%b, required %h/0",
                         i, bus.ghr_out, bus.pred_direct, exp_ghr());
            end
        end
        bus.stallreq   = 1'b0;
        bus.pred_valid = 1'b0;
        cycle();
        idle_inputs();
        bus.pred_pc_idx = 8'h70 ^ exp_ghr();
        #1;
        checks++;
        if (bus.pred_direct !== exp_dir(8'h70)) begin
            errors++;
            $display("FAIL stall_release_n1: dir=%b, required %b", bus.pred_direct, exp_dir(8'h70));
        end
        cycle();
        checks++;
        if (bus.pred_direct !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_n2: dir=%b, required 1", bus.pred_direct);
        end
        set_upd(8'h70, 1'b0);
        cycle();
        idle_inputs();
        cycle();
        checks++;
        if (bus.pred_direct !== 1'b0) begin
            errors++;
            $display("FAIL stall_once: dir=%b, required 0 (one step applied)", bus.pred_direct);
        end
    endtask

    task automatic test_random();
        logic [7:0] idx_set [8];
        for (int i = 0; i < 8; i++) idx_set[i] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 400; n++) begin
            resetn             = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            bus.stallreq       = ($urandom_range(0, 99) < 20);
            bus.pred_valid     = $urandom_range(0, 1);
            bus.pred_pc_idx    = ($urandom_range(0, 1) != 0) ? (idx_set[$urandom_range(0, 7)] ^ m_ghr)
                                                              : 8'($urandom_range(0, 255));
            bus.upd_valid      = $urandom_range(0, 1);
            bus.upd_index      = idx_set[$urandom_range(0, 7)];
            bus.upd_taken      = $urandom_range(0, 1);
            bus.upd_mispredict = ($urandom_range(0, 99) < 20);
            bus.upd_ghr        = 8'($urandom_range(0, 255));
            #1;
            checks++;
            if (bus.pred_direct !== exp_dir(bus.pred_pc_idx ^ exp_ghr())
                || bus.pred_index !== (bus.pred_pc_idx ^ exp_ghr())
                || bus.ghr_out !== exp_ghr()) begin
                errors++;
                $display("FAIL random[%0d]: dir=%b idx=%h ghr=%h, required %b/%h/%h", n,
                         bus.pred_direct, bus.pred_index, bus.ghr_out,
                         exp_dir(bus.pred_pc_idx ^ exp_ghr()), bus.pred_pc_idx ^ exp_ghr(), exp_ghr());
            end
            cycle();
        end
        resetn = 1'b1;
        idle_inputs();
    endtask

    initial begin
        foreach (m_cnt[i]) begin
            m_cnt[i] = 0;
            m_val[i] = 1'b0;
        end
        m_ghr = 8'h00;
        pend  = 1'b0;
        test_reset();
        test_first_update();
        test_saturation();
        test_back_to_back();
        test_ghr();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
